// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data memory.
// The processor has fixed priority; an aging counter bounds how long the host can be starved.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned STARVE   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] StarveCnt = 4'(STARVE);

    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [READ_LAT-1:0] vld_q, own_q;  // own: 1 = host issued the read
    logic [DATA_W-1:0]   p_rdata_q, h_rdata_q;
    logic                force_h, h_win, p_win, issue_rd;

    // Grants are gated by reset so every output reads low while reset is held.
    always_comb begin
        force_h  = (wait_cnt_q == StarveCnt);
        h_win    = reset & h_req & (force_h | ~p_req);
        p_win    = reset & p_req & ~h_win;
        p_gnt    = p_win;
        h_gnt    = h_win;
        issue_rd = (p_win & ~p_we) | (h_win & ~h_we);

        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (h_win) begin
            mem_address = h_addr;
            mem_data    = h_wdata;
            mem_wren    = h_we;
        end else if (p_win) begin
            mem_address = p_addr;
            mem_data    = p_wdata;
            mem_wren    = p_we;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!h_req || h_win) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != StarveCnt) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        p_rvalid = vld_q[READ_LAT-1] & ~own_q[READ_LAT-1];
        h_rvalid = vld_q[READ_LAT-1] & own_q[READ_LAT-1];
        p_rdata  = p_rvalid ? mem_q : p_rdata_q;
        h_rdata  = h_rvalid ? mem_q : h_rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 4'd0;
            vld_q      <= '0;
            own_q      <= '0;
            p_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            for (int i = READ_LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
            vld_q[0] <= issue_rd;
            own_q[0] <= h_win;
            if (p_rvalid) p_rdata_q <= mem_q;
            if (h_rvalid) h_rdata_q <= mem_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle synchronous-read memory model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p_req = 1'b0, p_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
    logic [11:0] p_addr = '0, h_addr = '0;
    logic [31:0] p_wdata = '0, h_wdata = '0;
    logic        p_gnt, p_rvalid, h_gnt, h_rvalid, mem_wren;
    logic [31:0] p_rdata, h_rdata, mem_data;
    logic [11:0] mem_address;
    logic [31:0] mem_q = '0;
    logic [31:0] mem [4096];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    dmem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .p_req      (p_req),
        .p_we       (p_we),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_gnt      (p_gnt),
        .p_rvalid   (p_rvalid),
        .p_rdata    (p_rdata),
        .h_req      (h_req),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .h_gnt      (h_gnt),
        .h_rvalid   (h_rvalid),
        .h_rdata    (h_rdata),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    task automatic test_reset();
        p_req = 1'b1; p_we = 1'b1; p_addr = 12'h123; p_wdata = 32'h0BADF00D;
        h_req = 1'b1; h_we = 1'b1; h_addr = 12'h456; h_wdata = 32'h0BADCAFE;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({p_gnt, h_gnt, mem_wren, p_rvalid, h_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL rst_ctl: got %b want 00000", {p_gnt, h_gnt, mem_wren, p_rvalid, h_rvalid});
        end
        checks++;
        if (mem_address !== 12'h0 || mem_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mem: got addr=%h data=%h want 0/0", mem_address, mem_data);
        end
        checks++;
        if (p_rdata !== 32'h0 || h_rdata !== 32'h0 || dut.wait_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL rst_state: got prd=%h hrd=%h wait=%0d want 0/0/0",
                     p_rdata, h_rdata, dut.wait_cnt_q);
        end
        @(negedge clock);
        p_req = 1'b0; h_req = 1'b0; p_we = 1'b0; h_we = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        p_req = 1'b1; p_we = 1'b1; p_addr = 12'h010; p_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (p_gnt !== 1'b1 || h_gnt !== 1'b0 || mem_wren !== 1'b1 || mem_address !== 12'h010 ||
            mem_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_issue: got gnt=%b/%b wren=%b addr=%h data=%h want 1/0 1 010 deadbeef",
                     p_gnt, h_gnt, mem_wren, mem_address, mem_data);
        end
        @(negedge clock);
        p_we = 1'b0;
        #1;
        checks++;
        if (p_gnt !== 1'b1 || mem_wren !== 1'b0 || p_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue: got gnt=%b wren=%b prv=%b hrv=%b want 1 0 0 0",
                     p_gnt, mem_wren, p_rvalid, h_rvalid);
        end
        @(negedge clock);
        p_req = 1'b0;
        #1;
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF || h_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_return: got prv=%b prd=%h hrv=%b want 1 deadbeef 0",
                     p_rvalid, p_rdata, h_rvalid);
        end
        @(negedge clock);
        #1;
        checks++;
        if (p_rvalid !== 1'b0 || p_rdata !== 32'hDEADBEEF || p_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold: got prv=%b prd=%h gnt=%b want 0 deadbeef 0",
                     p_rvalid, p_rdata, p_gnt);
        end
    endtask

    // Host writes preload data, exercising the host write path along the way.
    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        h_req = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
        #1;
        checks++;
        if (h_gnt !== 1'b1 || p_gnt !== 1'b0 || mem_wren !== 1'b1 || mem_address !== a ||
            mem_data !== d) begin
            errors++;
            $display("FAIL h_write: got gnt=%b/%b wren=%b addr=%h data=%h want 1/0 1 %h %h",
                     h_gnt, p_gnt, mem_wren, mem_address, mem_data, a, d);
        end
        @(negedge clock);
        h_req = 1'b0; h_we = 1'b0;
        #1;
        checks++;
        if (h_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL h_write_norv: got hrv=%b want 0", h_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [3:0] exp_wait;
        preload(12'h020, 32'hA5A50020);
        preload(12'h030, 32'h5A5A0030);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clock);
            p_req = 1'b1; p_we = 1'b0; p_addr = 12'h030;
            h_req = (c <= 4); h_we = 1'b0; h_addr = 12'h020;
            #1;
            exp_wait = (c <= 4) ? 4'(c) : 4'd0;
            checks++;
            if (h_gnt !== (c == 4) || p_gnt !== (c != 4) || dut.wait_cnt_q !== exp_wait) begin
                errors++;
                $display("FAIL starve_c%0d: got hg=%b pg=%b wait=%0d want %b %b %0d", c,
                         h_gnt, p_gnt, dut.wait_cnt_q, c == 4, c != 4, exp_wait);
            end
            checks++;
            if (h_rvalid !== (c == 5) || p_rvalid !== (c >= 1 && c != 5)) begin
                errors++;
                $display("FAIL starve_rv_c%0d: got hrv=%b prv=%b want %b %b", c,
                         h_rvalid, p_rvalid, c == 5, c >= 1 && c != 5);
            end
            if (c == 4 && mem_address !== 12'h020) begin
                errors++;
                $display("FAIL starve_addr: got %h want 020", mem_address);
            end
            if (c == 5) begin
                checks++;
                if (h_rdata !== 32'hA5A50020 || p_rdata !== 32'h5A5A0030) begin
                    errors++;
                    $display("FAIL starve_data: got hrd=%h prd=%h want a5a50020 5a5a0030",
                             h_rdata, p_rdata);
                end
            end
        end
        @(negedge clock);
        p_req = 1'b0; h_req = 1'b0;
    endtask

    task automatic test_interleaved();
        preload(12'h001, 32'h11111111);
        preload(12'h002, 32'h22222222);
        @(negedge clock);
        p_req = 1'b1; p_we = 1'b0; p_addr = 12'h001;
        #1;
        checks++;
        if (p_gnt !== 1'b1 || h_gnt !== 1'b0) begin
            errors++;
            $display("FAIL il_pgnt: got pg=%b hg=%b want 1 0", p_gnt, h_gnt);
        end
        @(negedge clock);
        p_req = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 12'h002;
        #1;
        checks++;
        if (h_gnt !== 1'b1 || p_rvalid !== 1'b1 || p_rdata !== 32'h11111111 || h_rvalid !== 1'b0)
        begin
            errors++;
            $display("FAIL il_p_ret: got hg=%b prv=%b prd=%h hrv=%b want 1 1 11111111 0",
                     h_gnt, p_rvalid, p_rdata, h_rvalid);
        end
        @(negedge clock);
        h_req = 1'b0;
        #1;
        checks++;
        if (h_rvalid !== 1'b1 || h_rdata !== 32'h22222222 || p_rvalid !== 1'b0 ||
            p_rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL il_h_ret: got hrv=%b hrd=%h prv=%b prd=%h want 1 22222222 0 11111111",
                     h_rvalid, h_rdata, p_rvalid, p_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        p_req = 1'b1; p_we = 1'b0; p_addr = 12'h010;
        #1;
        checks++;
        if (p_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mr_gnt: got %b want 1", p_gnt);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({p_gnt, h_gnt, mem_wren, p_rvalid, h_rvalid} !== 5'b0 || mem_address !== 12'h0 ||
            p_rdata !== 32'h0 || h_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mr_in_rst: got ctl=%b addr=%h prd=%h hrd=%h want 00000 000 0 0",
                     {p_gnt, h_gnt, mem_wren, p_rvalid, h_rvalid}, mem_address, p_rdata, h_rdata);
        end
        repeat (2) @(negedge clock);
        p_req = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (p_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL mr_no_rv_c%0d: got prv=%b hrv=%b want 0 0", c, p_rvalid, h_rvalid);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            p_req = 1'b0; h_req = 1'b0;
            #1;
            checks++;
            if (mem_wren !== 1'b0 || p_gnt !== 1'b0 || h_gnt !== 1'b0 ||
                dut.wait_cnt_q !== 4'd0) begin
                errors++;
                $display("FAIL idle_c%0d: got wren=%b pg=%b hg=%b wait=%0d want 0 0 0 0", c,
                         mem_wren, p_gnt, h_gnt, dut.wait_cnt_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_starvation();
        test_interleaved();
        test_reset_mid_read();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`dmem`, 12-bit address, 32-bit data, synchronous read) between the processor and a host loader/debug port. Each cycle it grants at most one requester and drives the memory port from the winner. It tracks in-flight reads so that read data returns to the requester that issued it. The processor has fixed priority, and an aging counter guarantees the host a grant after a bounded wait.

## Interface
- `ADDR_W`, 12, memory address width
- `DATA_W`, 32, memory data width
- `READ_LAT`, 1, cycles from issue edge to valid `mem_q` (1..4)
- `STARVE`, 4, host wait cycles before a forced host grant (1..15)

- `clock`  in  1  single clock for arbiter and dmem
- `reset`  in  1  asynchronous, active-low reset
- `p_req`  in  1  processor request; `p_we`, `p_addr`, `p_wdata` held stable until granted
- `p_we`  in  1  processor write enable
- `p_addr`  in  ADDR_W  processor address
- `p_wdata`  in  DATA_W  processor write data
- `p_gnt`  out  1  processor access issued this cycle
- `p_rvalid`  out  1  processor read data valid (one-cycle pulse)
- `p_rdata`  out  DATA_W  processor read data
- `h_req`, `h_we`, `h_addr`, `h_wdata`, `h_gnt`, `h_rvalid`, `h_rdata`: host port, with the same widths and meanings as the processor port
- `mem_address`  out  ADDR_W  to dmem `address`
- `mem_data`  out  DATA_W  to dmem `data`
- `mem_wren`  out  1  to dmem `wren`
- `mem_q`  in  DATA_W  from dmem `q`

## Operation
**Arbitration (combinational from registered state)**
- `force_h = (wait_cnt == STARVE)`.
- Winner is the host if `h_req & (force_h | ~p_req)`; otherwise the processor if `p_req`; otherwise none.
- `p_gnt` / `h_gnt` are high for the winner only. The two are never high together.
- `mem_address`, `mem_data`, and `mem_wren` come from the winner's fields. With no winner, `mem_wren=0`, `mem_address=0`, `mem_data=0`.

**Aging counter**
- `wait_cnt` is 4 bits and saturates at `STARVE`.
- It increments on each cycle where `h_req & ~h_gnt`.
- It clears on `h_gnt` or `~h_req`.

**Read tracking**
- A shift pipeline of depth `READ_LAT` carries {valid, owner}.
- A granted read (`gnt & ~we`) enters with valid=1 and owner=winner.
- At the pipeline output, valid pulses `p_rvalid` or `h_rvalid` for one cycle. The matching `*_rdata = mem_q`.
- Each `*_rdata` holds its last value otherwise.
- Writes produce no rvalid.

**Ordering and hazards**
- Accesses reach dmem strictly in grant order.
- A read issued the cycle after a write to the same address returns the written data.
- Because the pipeline advances one stage per cycle, returns are in issue order and never collide.

**Reset behaviour**
- While `reset=0`, all outputs are held low: gnt, rvalid, `mem_wren`, `mem_address`, `mem_data`, and `*_rdata` = 0.
- `wait_cnt=0`, and the pipeline valids are cleared.
- Reset asserted mid-read discards the pending return; no rvalid follows deassertion.

## Timing
- Grant is same-cycle. A request sampled high in cycle N with a win gives gnt high in cycle N, and dmem captures at the rising edge ending cycle N.
- Read data arrives as `*_rvalid` high in cycle N+`READ_LAT`.
- Back-to-back grants to either port are allowed every cycle.
- The requester deasserts or changes fields only after the cycle in which gnt is high.
- Worst-case host wait with the processor continuously requesting: `STARVE` cycles. The grant comes in cycle `STARVE` after the first blocked cycle.
- Worst-case processor wait: 1 cycle per forced host grant.
- Reset is asynchronous on assertion. Release is synchronized externally; the first arbitration happens in the first clock after release.

## Test plan
- **Processor write then read:** `p_req`, `p_we=1`, `p_addr=0x010`, `p_wdata=0xDEADBEEF` for one cycle, then a read of 0x010 → `p_gnt` high both cycles; `p_rvalid` high exactly `READ_LAT` cycles after the read grant with `p_rdata=0xDEADBEEF`; `h_rvalid` stays 0.
- **Simultaneous requests:** `p_req` and `h_req` both high, `wait_cnt=0` → `p_gnt=1`, `h_gnt=0`, `wait_cnt=1`.
- **Starvation:** `p_req` held high continuously, host read of 0x020 held from cycle 0 → `h_gnt` in cycle 4 (`STARVE=4`) with `p_gnt=0` that cycle; `wait_cnt` returns to 0; processor is granted again in cycle 5.
- **Interleaved reads:** processor read 0x001 (pre-loaded 0x11111111) in cycle N, host read 0x002 (pre-loaded 0x22222222) in N+1, `READ_LAT=1` → `p_rvalid`/0x11111111 in N+1, `h_rvalid`/0x22222222 in N+2, with no overlap.
- **Reset mid-read:** processor read granted in cycle N, `reset` low during N+1 before the return edge → no `p_rvalid` after release; all outputs are 0 during reset.
- **Idle:** no requests for 10 cycles → `mem_wren=0`, both gnt 0, `wait_cnt=0`.
